segment_scan_bank: RTL and testbench

Parametrised seven-segment display register bank with built-in digit scan multiplexing. It generalises the single-digit latch into a bank of DIGITS pattern registers. Each register is loaded from the multiplier/decoder path on `done` for its own `seg_mux_sel` index. A prescaled scan counter time-multiplexes the stored patterns onto one shared segment bus with active-low digit enables. The block sits between the result-to-segment decoder and the board's display pins.

---
 rtl/segment_scan_bank.sv | 115 +++++++++++
 tb/tb_segment_scan_bank.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/segment_scan_bank.sv
// Bank of seven-segment pattern registers with a prescaled digit scanner.
// Optional macro SEG_GHOST_BLANK_EN forces all anodes off for the first BLANK_CYC cycles of each slot.
module segment_scan_bank #(
    parameter int               DIGITS      = 8,
    parameter int               SEL_W       = 3,
    parameter int               SEG_W       = 7,
    parameter logic [SEG_W-1:0] RST_PATTERN = 7'b0000001,
    parameter int               SCAN_DIV    = 50000,
    parameter int               BLANK_CYC   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [SEG_W-1:0]   in,
    input  logic [SEL_W-1:0]   seg_mux_sel,
    input  logic               done,
    input  logic               clear,
    output logic [SEG_W-1:0]   seg_out,
    output logic [DIGITS-1:0]  an,
    output logic [SEL_W-1:0]   scan_idx,
    output logic               frame_tick
);

    localparam int                PCNT_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(SCAN_DIV - 1);
    localparam logic [SEL_W-1:0]  IDX_LAST  = SEL_W'(DIGITS - 1);

    if (SCAN_DIV < 2) begin : g_bad_scan_div
        $error("segment_scan_bank: SCAN_DIV must be at least 2");
    end
    if (DIGITS < 1 || DIGITS > (1 << SEL_W)) begin : g_bad_digits
        $error("segment_scan_bank: DIGITS must lie in 1..2**SEL_W");
    end
    if (BLANK_CYC >= SCAN_DIV) begin : g_bad_blank
        $error("segment_scan_bank: BLANK_CYC must be below SCAN_DIV");
    end

    logic [SEG_W-1:0]  digit [DIGITS];
    logic [PCNT_W-1:0] pcnt_p0;
    logic [SEL_W-1:0]  scan_idx_p0;
    logic              slot_end;
    logic              frame_end;
    logic [SEG_W-1:0]  seg_sel;
    logic [DIGITS-1:0] an_sel;
    logic              an_blank;
    logic [SEG_W-1:0]  seg_p1;
    logic [DIGITS-1:0] an_p1;
    logic              tick_p1;

    assign slot_end  = (pcnt_p0 == PCNT_LAST);
    assign frame_end = slot_end && (scan_idx_p0 == IDX_LAST);

    // Stage p0: pattern storage; clear outranks a same-cycle load, out-of-range selects match no register
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            for (int i = 0; i < DIGITS; i++) begin
                digit[i] <= RST_PATTERN;
            end
        end else if (done) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (seg_mux_sel == SEL_W'(i)) begin
                    digit[i] <= in;
                end
            end
        end
    end

    // Stage p0: prescaler and scan index, free-running regardless of loads
    always_ff @(posedge clk) begin
        if (!rst) begin
            pcnt_p0     <= '0;
            scan_idx_p0 <= '0;
        end else if (slot_end) begin
            pcnt_p0     <= '0;
            scan_idx_p0 <= (scan_idx_p0 == IDX_LAST) ? '0 : scan_idx_p0 + SEL_W'(1);
        end else begin
            pcnt_p0     <= pcnt_p0 + PCNT_W'(1);
        end
    end

    always_comb begin
        seg_sel = RST_PATTERN;
        an_sel  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (scan_idx_p0 == SEL_W'(i)) begin
                seg_sel   = digit[i];
                an_sel[i] = 1'b0;
            end
        end
    end

`ifdef SEG_GHOST_BLANK_EN
    assign an_blank = (pcnt_p0 < PCNT_W'(BLANK_CYC));
`else
    assign an_blank = 1'b0;
`endif

    // Stage p1: registered display outputs, one cycle behind the scan index
    always_ff @(posedge clk) begin
        if (!rst) begin
            seg_p1  <= RST_PATTERN;
            an_p1   <= '1;
            tick_p1 <= 1'b0;
        end else begin
            seg_p1  <= seg_sel;
            an_p1   <= an_blank ? '1 : an_sel;
            tick_p1 <= frame_end;
        end
    end

    assign seg_out    = seg_p1;
    assign an         = an_p1;
    assign scan_idx   = scan_idx_p0;
    assign frame_tick = tick_p1;

endmodule

// File: tb/tb_segment_scan_bank.sv
// Scoreboard bench for segment_scan_bank with DIGITS=4, SCAN_DIV=4, BLANK_CYC=1.
module tb_segment_scan_bank;

    localparam int         DIGITS    = 4;
    localparam int         SEL_W     = 3;
    localparam int         SEG_W     = 7;
    localparam int         SCAN_DIV  = 4;
    localparam int         BLANK_CYC = 1;
    localparam logic [6:0] RP        = 7'b0000001;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] in_pat;
    logic [2:0] sel;
    logic       done;
    logic       clear;
    logic [6:0] seg_out;
    logic [3:0] an;
    logic [2:0] scan_idx;
    logic       frame_tick;

    always #5 clk = ~clk;

    segment_scan_bank #(
        .DIGITS(DIGITS), .SEL_W(SEL_W), .SEG_W(SEG_W), .RST_PATTERN(RP),
        .SCAN_DIV(SCAN_DIV), .BLANK_CYC(BLANK_CYC)
    ) dut (
        .clk(clk), .rst(rst), .in(in_pat), .seg_mux_sel(sel), .done(done), .clear(clear),
        .seg_out(seg_out), .an(an), .scan_idx(scan_idx), .frame_tick(frame_tick)
    );

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic [2:0] idx;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    logic [6:0] m_digit [DIGITS];
    int         m_pcnt;
    int         m_idx;

    // Predict the outputs produced by the next edge from the inputs now applied, then take that edge.
    task automatic cycle();
        exp_t       e;
        logic [3:0] a;
        logic       blank;
        if (!rst) begin
            for (int i = 0; i < DIGITS; i++) m_digit[i] = RP;
            m_pcnt = 0;
            m_idx  = 0;
            e.seg  = RP;
            e.an   = 4'hF;
            e.tick = 1'b0;
            e.idx  = 3'd0;
        end else begin
`ifdef SEG_GHOST_BLANK_EN
            blank = (m_pcnt < BLANK_CYC);
`else
            blank = 1'b0;
`endif
            a = 4'hF;
            if (!blank) a[m_idx] = 1'b0;
            e.seg  = m_digit[m_idx];
            e.an   = a;
            e.tick = (m_pcnt == SCAN_DIV - 1) && (m_idx == DIGITS - 1);
            if (clear) begin
                for (int i = 0; i < DIGITS; i++) m_digit[i] = RP;
            end else if (done && sel < DIGITS) begin
                m_digit[sel] = in_pat;
            end
            if (m_pcnt == SCAN_DIV - 1) begin
                m_pcnt = 0;
                m_idx  = (m_idx + 1) % DIGITS;
            end else begin
                m_pcnt = m_pcnt + 1;
            end
            e.idx = 3'(m_idx);
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        exp_t e;
        rst = 1'b0; done = 1'b0; clear = 1'b0; sel = '0; in_pat = '0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            e = exp_q.pop_front();
            vectors++;
            if ({seg_out, an, scan_idx, frame_tick} !== e || an !== 4'b1111 || seg_out !== RP) begin
                errors++;
                $display("FAIL reset_hold: got seg=%b an=%b idx=%0d tick=%b, required seg=%b an=%b idx=%0d tick=%b",
                         seg_out, an, scan_idx, frame_tick, e.seg, e.an, e.idx, e.tick);
            end
        end
        rst = 1'b1;
        cycle();
        e = exp_q.pop_front();
        vectors++;
`ifdef SEG_GHOST_BLANK_EN
        if ({seg_out, an, scan_idx, frame_tick} !== e || an !== 4'b1111 || seg_out !== RP) begin
`else
        if ({seg_out, an, scan_idx, frame_tick} !== e || an !== 4'b1110 || seg_out !== RP) begin
`endif
            errors++;
            $display("FAIL reset_release: got seg=%b an=%b idx=%0d tick=%b, required seg=%b an=%b idx=%0d tick=%b",
                     seg_out, an, scan_idx, frame_tick, e.seg, e.an, e.idx, e.tick);
        end
    endtask

    task automatic test_out_of_range();
        exp_t e;
        done = 1'b1; sel = 3'd5; in_pat = 7'b1111111;
        cycle();
        e = exp_q.pop_front();
        done = 1'b0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            e = exp_q.pop_front();
            vectors++;
            if ({seg_out, an, scan_idx, frame_tick} !== e || seg_out !== RP) begin
                errors++;
                $display("FAIL out_of_range: got seg=%b an=%b idx=%0d, required seg=%b an=%b idx=%0d",
                         seg_out, an, scan_idx, e.seg, e.an, e.idx);
            end
        end
    endtask

    task automatic test_load_scan();
        exp_t e;
        int   hits = 0;
        done = 1'b1; sel = 3'd2; in_pat = 7'b0010010;
        cycle();
        e = exp_q.pop_front();
        done = 1'b0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            e = exp_q.pop_front();
            vectors++;
            if ({seg_out, an, scan_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL load_scan_sb: got seg=%b an=%b idx=%0d tick=%b, required seg=%b an=%b idx=%0d tick=%b",
                         seg_out, an, scan_idx, frame_tick, e.seg, e.an, e.idx, e.tick);
            end
            if (an == 4'b1011) begin
                hits++;
                vectors++;
                if (seg_out !== 7'b0010010) begin
                    errors++;
                    $display("FAIL load_scan_digit2: got seg=%b, required %b", seg_out, 7'b0010010);
                end
            end else if (an != 4'b1111) begin
                vectors++;
                if (seg_out !== RP) begin
                    errors++;
                    $display("FAIL load_scan_other: an=%b got seg=%b, required %b", an, seg_out, RP);
                end
            end
        end
        vectors++;
        if (hits == 0) begin
            errors++;
            $display("FAIL load_scan_slot: got %0d cycles with an=1011, required at least 1", hits);
        end
    endtask

    task automatic test_clear_vs_done();
        exp_t e;
        done = 1'b1; sel = 3'd1; in_pat = 7'b0110000;
        cycle();
        e = exp_q.pop_front();
        clear = 1'b1; done = 1'b1; sel = 3'd1; in_pat = 7'b1001111;
        cycle();
        e = exp_q.pop_front();
        clear = 1'b0; done = 1'b0;
        for (int c = 0; c < 16; c++) begin
            cycle();
            e = exp_q.pop_front();
            vectors++;
            if ({seg_out, an, scan_idx, frame_tick} !== e || seg_out !== RP) begin
                errors++;
                $display("FAIL clear_vs_done: got seg=%b an=%b idx=%0d, required seg=%b an=%b idx=%0d",
                         seg_out, an, scan_idx, e.seg, e.an, e.idx);
            end
        end
    endtask

    task automatic test_wrap_and_blank();
        exp_t       e;
        logic [3:0] want_an;
        logic [2:0] prev_idx;
        int         ticks[$];
        rst = 1'b0;
        cycle();
        e = exp_q.pop_front();
        rst = 1'b1;
        prev_idx = 3'd0;
        for (int c = 1; c <= 32; c++) begin
            cycle();
            e = exp_q.pop_front();
            vectors++;
            if ({seg_out, an, scan_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL wrap_sb: got seg=%b an=%b idx=%0d tick=%b, required seg=%b an=%b idx=%0d tick=%b",
                         seg_out, an, scan_idx, frame_tick, e.seg, e.an, e.idx, e.tick);
            end
            want_an = ~(4'b0001 << (((c - 1) / SCAN_DIV) % DIGITS));
`ifdef SEG_GHOST_BLANK_EN
            if (((c - 1) % SCAN_DIV) < BLANK_CYC) want_an = 4'b1111;
`endif
            vectors++;
            if (an !== want_an) begin
                errors++;
                $display("FAIL slot_an cycle %0d: got an=%b, required %b", c, an, want_an);
            end
            if (frame_tick === 1'b1) begin
                ticks.push_back(c);
                vectors++;
                if (prev_idx !== 3'd3 || scan_idx !== 3'd0) begin
                    errors++;
                    $display("FAIL tick_wrap: got idx %0d -> %0d, required 3 -> 0", prev_idx, scan_idx);
                end
            end
            prev_idx = scan_idx;
        end
        vectors++;
        if (ticks.size() != 2) begin
            errors++;
            $display("FAIL tick_count: got %0d pulses, required 2", ticks.size());
        end else begin
            vectors++;
            if (ticks[1] - ticks[0] != DIGITS * SCAN_DIV) begin
                errors++;
                $display("FAIL tick_period: got %0d cycles, required %0d", ticks[1] - ticks[0], DIGITS * SCAN_DIV);
            end
        end
    endtask

    task automatic test_back_to_back();
        exp_t e;
        for (int c = 0; c < 64; c++) begin
            if (c < 8) begin
                done = 1'b1; sel = 3'(c % DIGITS); in_pat = 7'(c * 19 + 5); clear = 1'b0;
            end else begin
                done   = 1'($urandom_range(0, 1));
                sel    = 3'($urandom_range(0, 7));
                in_pat = 7'($urandom);
                clear  = ($urandom_range(0, 15) == 0);
            end
            cycle();
            e = exp_q.pop_front();
            vectors++;
            if ({seg_out, an, scan_idx, frame_tick} !== e) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got seg=%b an=%b idx=%0d tick=%b, required seg=%b an=%b idx=%0d tick=%b",
                         c, seg_out, an, scan_idx, frame_tick, e.seg, e.an, e.idx, e.tick);
            end
        end
        done = 1'b0; clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_out_of_range();
        test_load_scan();
        test_clear_vs_done();
        test_wrap_and_blank();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
